// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIVIDER_SPECIAL_BYPASS_EN: divide-by-zero and signed-overflow
// requests leave BUSY after a single cycle instead of iterating.
module iterative_divider #(
  parameter int unsigned dataWidth   = 32,
  parameter int unsigned selectWidth = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [dataWidth-1:0]   inputA,
  input  logic [dataWidth-1:0]   inputB,
  input  logic [selectWidth-1:0] divSelect,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [dataWidth-1:0]   dataOut,
  output logic                   busy
);

  localparam int unsigned W        = dataWidth;
  localparam int unsigned CntWidth = $clog2(dataWidth);
  localparam logic [CntWidth-1:0] CntStart = CntWidth'(dataWidth - 1);
  localparam logic [W-1:0]        MostNeg  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        dq_q, dq_d;        // dividend shifts out MSB-first, quotient shifts in
  logic [W-1:0]        div_q, div_d;      // absolute divisor
  logic [W-1:0]        rem_q, rem_d;      // partial remainder, always < divisor
  logic [W-1:0]        raw_a_q, raw_a_d;  // original dividend for divide-by-zero REM
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                is_rem_q, is_rem_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic [W-1:0]        result_q, result_d;

  // Request decode: signedness, absolute operands and special cases
  logic         op_signed, a_neg, b_neg, req_zero, req_ovf;
  logic [W-1:0] abs_a, abs_b;

  assign op_signed = ~divSelect[0];
  assign a_neg     = op_signed & inputA[W-1];
  assign b_neg     = op_signed & inputB[W-1];
  assign abs_a     = a_neg ? -inputA : inputA;
  assign abs_b     = b_neg ? -inputB : inputB;
  assign req_zero  = (inputB == '0);
  assign req_ovf   = op_signed & (inputA == MostNeg) & (inputB == '1);

  // One restoring step on a dataWidth+1 bit partial remainder
  logic [W:0]   rem_shift, rem_diff;
  logic         q_bit;
  logic [W-1:0] rem_iter, dq_iter;

  assign rem_shift = {rem_q, dq_q[W-1]};
  assign rem_diff  = rem_shift - {1'b0, div_q};
  assign q_bit     = ~rem_diff[W];
  assign rem_iter  = q_bit ? rem_diff[W-1:0] : rem_shift[W-1:0];
  assign dq_iter   = {dq_q[W-2:0], q_bit};

  // Sign correction and special-case override, applied on the way into DONE
  logic [W-1:0] quo_fin, rem_fin, special_res, final_res;

  assign quo_fin     = neg_quo_q ? -dq_iter : dq_iter;
  assign rem_fin     = neg_rem_q ? -rem_iter : rem_iter;
  assign special_res = zero_q ? (is_rem_q ? raw_a_q : '1) : (is_rem_q ? '0 : MostNeg);
  assign final_res   = (zero_q || ovf_q) ? special_res : (is_rem_q ? rem_fin : quo_fin);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      dq_q      <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      raw_a_q   <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      dq_q      <= dq_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      raw_a_q   <= raw_a_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    dq_d      = dq_q;
    div_d     = div_q;
    rem_d     = rem_q;
    raw_a_d   = raw_a_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    inReady   = 1'b0;
    busy      = 1'b0;
    outValid  = 1'b0;
    dataOut   = '0;

    case (state_q)
      StIdle: begin
        inReady = 1'b1;
        if (inValid) begin
          state_d   = StBusy;
          dq_d      = abs_a;
          div_d     = abs_b;
          rem_d     = '0;
          raw_a_d   = inputA;
          cnt_d     = CntStart;
          is_rem_d  = divSelect[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          zero_d    = req_zero;
          ovf_d     = req_ovf;
        end
      end
      StBusy: begin
        busy  = 1'b1;
        dq_d  = dq_iter;
        rem_d = rem_iter;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = StDone;
          result_d = final_res;
        end
`ifdef DIVIDER_SPECIAL_BYPASS_EN
        if (zero_q || ovf_q) begin
          state_d  = StDone;
          result_d = special_res;
        end
`else
`endif
      end
      StDone: begin
        outValid = 1'b1;
        dataOut  = result_q;
        if (outReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
